control_logic: RTL and testbench

// - Z80-style CPU bus sequencer: generates M1 opcode-fetch/refresh, memory-read, interrupt-ack and bus-grant cycles.
// - Tracks PC, R, IFF1/IFF2 and HALT; decodes NOP, HALT, JP nn, DI and EI. Sits between the core datapath and the external bus.
// - Read-only bus: no data_out. Stack pushes for interrupts are not performed.

---
 rtl/z80_pkg.sv | 53 +++++
 rtl/z80_decode.sv | 34 +++
 rtl/control_logic.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_control_logic.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/z80_pkg.sv
// ---------------------------------------------------------------------------
// z80_pkg
// Shared types and constants for the Z80-style bus sequencer.
//   mcycle_t : machine-cycle kind (opcode fetch, operand reads, interrupt
//              acknowledge, NMI dummy fetch, bus grant)
//   tstate_t : T-state within a machine cycle (TW = inserted wait state)
//   dec_t    : decoded opcode flags produced by z80_decode
//   OP_*     : supported opcodes, VEC_* : interrupt restart addresses
// ---------------------------------------------------------------------------
package z80_pkg;

  typedef enum logic [2:0] {
    M1     = 3'd0,
    MR_LO  = 3'd1,
    MR_HI  = 3'd2,
    INTA   = 3'd3,
    NMIA   = 3'd4,
    BUSGNT = 3'd5
  } mcycle_t;

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    TW = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_t;

  typedef struct packed {
    logic halt;
    logic jp;
    logic di;
    logic ei;
  } dec_t;

  localparam dec_t DEC_NONE = 4'b0000;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HALT = 8'h76;
  localparam logic [7:0] OP_JP   = 8'hC3;
  localparam logic [7:0] OP_DI   = 8'hF3;
  localparam logic [7:0] OP_EI   = 8'hFB;

  localparam logic [15:0] VEC_NMI = 16'h0066;
  localparam logic [15:0] VEC_INT = 16'h0038;

  // The refresh counter only advances its low seven bits; bit 7 is
  // software-owned and must survive every refresh.
  function automatic logic [7:0] refresh_next(input logic [7:0] r);
    return {r[7], r[6:0] + 7'd1};
  endfunction

endpackage

// File: rtl/z80_decode.sv
// ---------------------------------------------------------------------------
// z80_decode
// Maps the latched opcode to instruction flags. Only meaningful while the
// sequencer is in the decode slot of a live (non-halted) opcode fetch.
//   i_valid  in  1  decode slot active
//   i_opcode in  8  latched opcode byte
//   o_dec    out 4  {halt, jp, di, ei}; all zero for NOP/unknown/invalid
// ---------------------------------------------------------------------------
module z80_decode
  import z80_pkg::*;
(
  input  logic       i_valid,
  input  logic [7:0] i_opcode,
  output dec_t       o_dec
);

  // Opcode to flag mapping; everything unrecognised executes as NOP
  always_comb begin
    o_dec = DEC_NONE;
    if (i_valid) begin
      case (i_opcode)
        OP_NOP:  o_dec = DEC_NONE;
        OP_HALT: o_dec.halt = 1'b1;
        OP_JP:   o_dec.jp   = 1'b1;
        OP_DI:   o_dec.di   = 1'b1;
        OP_EI:   o_dec.ei   = 1'b1;
        default: o_dec = DEC_NONE;
      endcase
    end else begin
      o_dec = DEC_NONE;
    end
  end

endmodule

// File: rtl/control_logic.sv
// ---------------------------------------------------------------------------
// control_logic
// Z80-style CPU bus sequencer: opcode fetch with refresh, operand memory
// reads, interrupt acknowledge, NMI response and bus grant. One clk is one
// T-state. All outputs are registered (decoded from the next state), so
// there is no combinational path from any input to any output.
//   clk       in   1  clock, all state on posedge
//   rst       in   1  synchronous active-high reset
//   data_in   in   8  bus data, sampled at the end of the last T2/TW
//   addr_out  out 16  address bus
//   M1_L      out  1  opcode-fetch / interrupt-ack cycle marker
//   MREQ_L    out  1  memory request
//   IORQ_L    out  1  I/O request (interrupt acknowledge only)
//   RD_L      out  1  read strobe
//   WR_L      out  1  write strobe, tied inactive (read-only bus)
//   RFSH_L    out  1  refresh strobe (T3/T4 of fetch cycles)
//   HALT_L    out  1  low while halted
//   BUSACK_L  out  1  bus granted to an external master
//   INT_L     in   1  maskable interrupt, level sensitive
//   NMI_L     in   1  non-maskable interrupt, falling-edge latched
//   WAIT_L    in   1  wait request, sampled at the end of T2/TW
//   BUSREQ_L  in   1  external bus request
// ---------------------------------------------------------------------------
module control_logic
  import z80_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  output logic [15:0] addr_out,
  output logic        M1_L,
  output logic        MREQ_L,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L,
  output logic        RFSH_L,
  output logic        HALT_L,
  output logic        BUSACK_L,
  input  logic        INT_L,
  input  logic        NMI_L,
  input  logic        WAIT_L,
  input  logic        BUSREQ_L
);

  // Sequencer state
  mcycle_t     r_mcycle;
  tstate_t     r_tstate;
  logic        r_started;
  logic [15:0] r_pc;
  logic [7:0]  r_r;
  logic        r_iff1;
  logic        r_iff2;
  logic        r_halted;
  logic        r_nmi_latch;
  logic        r_nmi_prev;
  logic        r_int_blk;
  logic [7:0]  r_opcode;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic [1:0]  r_forced;

  // Registered bus outputs
  logic [15:0] r_addr;
  logic        r_m1_l;
  logic        r_mreq_l;
  logic        r_iorq_l;
  logic        r_rd_l;
  logic        r_rfsh_l;
  logic        r_halt_l;
  logic        r_busack_l;

  // Next-state values
  mcycle_t     w_mcycle;
  tstate_t     w_tstate;
  logic [15:0] w_pc;
  logic [7:0]  w_r;
  logic        w_iff1;
  logic        w_iff2;
  logic        w_halted;
  logic        w_nmi_latch;
  logic        w_int_blk;
  logic [7:0]  w_opcode;
  logic [7:0]  w_lo;
  logic [7:0]  w_hi;
  logic [1:0]  w_forced;
  logic        w_boundary;

  // Misc combinational
  logic        w_nmi_edge;
  logic        w_dec_valid;
  logic        w_int_ok;
  dec_t        w_dec;

  // Next-state output decode
  logic [15:0] w_o_addr;
  logic        w_o_m1_l;
  logic        w_o_mreq_l;
  logic        w_o_iorq_l;
  logic        w_o_rd_l;
  logic        w_o_rfsh_l;
  logic        w_o_halt_l;
  logic        w_o_busack_l;

  assign w_nmi_edge  = r_nmi_prev & ~NMI_L;
  // A halted CPU keeps fetching but executes nothing it reads.
  assign w_dec_valid = r_started && (r_mcycle == M1) && (r_tstate == T4) && !r_halted;

  z80_decode u_decode (
    .i_valid  (w_dec_valid),
    .i_opcode (r_opcode),
    .o_dec    (w_dec)
  );

  // INT is refused at the boundary of EI/DI themselves, and across a bus
  // grant that directly follows EI, until one more instruction has started.
  assign w_int_ok = !INT_L && r_iff1 && !r_int_blk && !w_dec.di && !w_dec.ei;

  // Next-state logic: T-state/M-cycle sequencing, then boundary arbitration
  always_comb begin
    w_mcycle    = r_mcycle;
    w_tstate    = r_tstate;
    w_pc        = r_pc;
    w_r         = r_r;
    w_iff1      = r_iff1;
    w_iff2      = r_iff2;
    w_halted    = r_halted;
    w_nmi_latch = r_nmi_latch | w_nmi_edge;
    w_int_blk   = r_int_blk;
    w_opcode    = r_opcode;
    w_lo        = r_lo;
    w_hi        = r_hi;
    w_forced    = r_forced;
    w_boundary  = 1'b0;

    if (!r_started) begin
      // First clock after reset: present M1 T1 without advancing
      w_mcycle = M1;
      w_tstate = T1;
    end else begin
      case (r_mcycle)
        M1, NMIA, INTA: begin
          case (r_tstate)
            T1: begin
              w_tstate = T2;
              if (r_mcycle == M1) begin
                w_int_blk = 1'b0;
              end else begin
                w_int_blk = r_int_blk;
              end
            end
            T2, TW: begin
              if ((r_mcycle == INTA) && (r_forced != 2'd0)) begin
                // Acknowledge cycles always carry two automatic waits
                w_tstate = TW;
                w_forced = r_forced - 2'd1;
              end else if (!WAIT_L) begin
                w_tstate = TW;
              end else begin
                w_tstate = T3;
                // NMI dummy fetch and INTA discard the byte and keep PC
                if ((r_mcycle == M1) && !r_halted) begin
                  w_opcode = data_in;
                  w_pc     = r_pc + 16'd1;
                end else begin
                  w_opcode = r_opcode;
                  w_pc     = r_pc;
                end
              end
            end
            T3: begin
              w_tstate = T4;
            end
            T4: begin
              w_r        = refresh_next(r_r);
              w_mcycle   = M1;
              w_tstate   = T1;
              w_boundary = 1'b1;
              if (r_mcycle == NMIA) begin
                w_pc = VEC_NMI;
              end else if (r_mcycle == INTA) begin
                w_pc = VEC_INT;
              end else begin
                if (w_dec.jp) begin
                  w_mcycle   = MR_LO;
                  w_boundary = 1'b0;
                end else begin
                  w_mcycle = M1;
                end
                if (w_dec.halt) begin
                  w_halted = 1'b1;
                end else begin
                  w_halted = r_halted;
                end
                if (w_dec.di) begin
                  w_iff1 = 1'b0;
                  w_iff2 = 1'b0;
                end else if (w_dec.ei) begin
                  w_iff1    = 1'b1;
                  w_iff2    = 1'b1;
                  w_int_blk = 1'b1;
                end else begin
                  w_iff1 = r_iff1;
                end
              end
            end
            default: begin
              w_mcycle = M1;
              w_tstate = T1;
            end
          endcase
        end

        MR_LO, MR_HI: begin
          case (r_tstate)
            T1: begin
              w_tstate = T2;
            end
            T2, TW: begin
              if (!WAIT_L) begin
                w_tstate = TW;
              end else begin
                w_tstate = T3;
                w_pc     = r_pc + 16'd1;
                if (r_mcycle == MR_LO) begin
                  w_lo = data_in;
                end else begin
                  w_hi = data_in;
                end
              end
            end
            T3: begin
              if (r_mcycle == MR_LO) begin
                w_mcycle = MR_HI;
                w_tstate = T1;
              end else begin
                w_pc       = {r_hi, r_lo};
                w_mcycle   = M1;
                w_tstate   = T1;
                w_boundary = 1'b1;
              end
            end
            default: begin
              w_mcycle = M1;
              w_tstate = T1;
            end
          endcase
        end

        BUSGNT: begin
          // On release, arbitrate again exactly as at the original boundary
          if (BUSREQ_L) begin
            w_mcycle   = M1;
            w_tstate   = T1;
            w_boundary = 1'b1;
          end else begin
            w_mcycle = BUSGNT;
            w_tstate = T1;
          end
        end

        default: begin
          w_mcycle = M1;
          w_tstate = T1;
        end
      endcase
    end

    // Instruction boundary: bus request > NMI > INT > next fetch
    if (w_boundary) begin
      if (!BUSREQ_L) begin
        w_mcycle = BUSGNT;
        w_tstate = T1;
      end else if (r_nmi_latch) begin
        w_mcycle    = NMIA;
        w_tstate    = T1;
        w_nmi_latch = w_nmi_edge;
        w_iff2      = w_iff1;
        w_iff1      = 1'b0;
        w_halted    = 1'b0;
      end else if (w_int_ok) begin
        w_mcycle = INTA;
        w_tstate = T1;
        w_iff1   = 1'b0;
        w_iff2   = 1'b0;
        w_halted = 1'b0;
        w_forced = 2'd2;
      end else begin
        w_forced = r_forced;
      end
    end else begin
      w_forced = w_forced;
    end
  end

  // Bus output decode of the next state (registered below)
  always_comb begin
    w_o_addr     = 16'h0000;
    w_o_m1_l     = 1'b1;
    w_o_mreq_l   = 1'b1;
    w_o_iorq_l   = 1'b1;
    w_o_rd_l     = 1'b1;
    w_o_rfsh_l   = 1'b1;
    w_o_halt_l   = ~w_halted;
    w_o_busack_l = 1'b1;
    case (w_mcycle)
      M1, NMIA, INTA: begin
        case (w_tstate)
          T1, T2, TW: begin
            w_o_addr = w_pc;
            w_o_m1_l = 1'b0;
            if (w_mcycle == INTA) begin
              w_o_iorq_l = 1'b0;
            end else begin
              w_o_mreq_l = 1'b0;
              w_o_rd_l   = 1'b0;
            end
          end
          T3: begin
            w_o_addr   = {8'h00, w_r};
            w_o_mreq_l = 1'b0;
            w_o_rfsh_l = 1'b0;
          end
          T4: begin
            w_o_addr   = {8'h00, w_r};
            w_o_rfsh_l = 1'b0;
          end
          default: begin
            w_o_addr = 16'h0000;
          end
        endcase
      end
      MR_LO, MR_HI: begin
        case (w_tstate)
          T1, T2, TW: begin
            w_o_addr   = w_pc;
            w_o_mreq_l = 1'b0;
            w_o_rd_l   = 1'b0;
          end
          T3: begin
            // PC has already moved on; keep the address that was read
            w_o_addr = r_addr;
          end
          default: begin
            w_o_addr = 16'h0000;
          end
        endcase
      end
      BUSGNT: begin
        w_o_busack_l = 1'b0;
      end
      default: begin
        w_o_addr = 16'h0000;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcycle    <= M1;
      r_tstate    <= T1;
      r_started   <= 1'b0;
      r_pc        <= 16'h0000;
      r_r         <= 8'h00;
      r_iff1      <= 1'b0;
      r_iff2      <= 1'b0;
      r_halted    <= 1'b0;
      r_nmi_latch <= 1'b0;
      r_nmi_prev  <= NMI_L;
      r_int_blk   <= 1'b0;
      r_opcode    <= 8'h00;
      r_lo        <= 8'h00;
      r_hi        <= 8'h00;
      r_forced    <= 2'd0;
    end else begin
      r_mcycle    <= w_mcycle;
      r_tstate    <= w_tstate;
      r_started   <= 1'b1;
      r_pc        <= w_pc;
      r_r         <= w_r;
      r_iff1      <= w_iff1;
      r_iff2      <= w_iff2;
      r_halted    <= w_halted;
      r_nmi_latch <= w_nmi_latch;
      r_nmi_prev  <= NMI_L;
      r_int_blk   <= w_int_blk;
      r_opcode    <= w_opcode;
      r_lo        <= w_lo;
      r_hi        <= w_hi;
      r_forced    <= w_forced;
    end
  end

  // Bus output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= 16'h0000;
      r_m1_l     <= 1'b1;
      r_mreq_l   <= 1'b1;
      r_iorq_l   <= 1'b1;
      r_rd_l     <= 1'b1;
      r_rfsh_l   <= 1'b1;
      r_halt_l   <= 1'b1;
      r_busack_l <= 1'b1;
    end else begin
      r_addr     <= w_o_addr;
      r_m1_l     <= w_o_m1_l;
      r_mreq_l   <= w_o_mreq_l;
      r_iorq_l   <= w_o_iorq_l;
      r_rd_l     <= w_o_rd_l;
      r_rfsh_l   <= w_o_rfsh_l;
      r_halt_l   <= w_o_halt_l;
      r_busack_l <= w_o_busack_l;
    end
  end

  assign addr_out = r_addr;
  assign M1_L     = r_m1_l;
  assign MREQ_L   = r_mreq_l;
  assign IORQ_L   = r_iorq_l;
  assign RD_L     = r_rd_l;
  assign WR_L     = 1'b1;
  assign RFSH_L   = r_rfsh_l;
  assign HALT_L   = r_halt_l;
  assign BUSACK_L = r_busack_l;

endmodule

// File: tb/tb_control_logic.sv
// ---------------------------------------------------------------------------
// tb_control_logic
// Directed bench for the bus sequencer. Each cyc() call advances to the next
// falling edge and compares the address bus and the strobe vector
// {M1_L,MREQ_L,IORQ_L,RD_L,WR_L,RFSH_L,HALT_L,BUSACK_L} against
// hand-computed values. Inputs changed after a cyc() are sampled at the
// rising edge that ends the T-state just observed.
// ---------------------------------------------------------------------------
module tb_control_logic;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic [15:0] addr_out;
  logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, HALT_L, BUSACK_L;
  logic        INT_L, NMI_L, WAIT_L, BUSREQ_L;
  logic [7:0]  strb;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe patterns, bit order {M1,MREQ,IORQ,RD,WR,RFSH,HALT,BUSACK}
  localparam logic [7:0] S_IDLE = 8'hFF;
  localparam logic [7:0] S_M1   = 8'h2F;  // fetch T1/T2/TW
  localparam logic [7:0] S_R3   = 8'hBB;  // refresh T3
  localparam logic [7:0] S_R4   = 8'hFB;  // refresh T4
  localparam logic [7:0] S_MR   = 8'hAF;  // memory read T1/T2
  localparam logic [7:0] S_IA   = 8'h5F;  // interrupt ack T1/T2/TW
  localparam logic [7:0] S_BG   = 8'hFE;  // bus granted
  localparam logic [7:0] S_M1H  = 8'h2D;  // halted variants
  localparam logic [7:0] S_R3H  = 8'hB9;
  localparam logic [7:0] S_R4H  = 8'hF9;

  assign strb = {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, HALT_L, BUSACK_L};

  always #5 clk = ~clk;

  control_logic dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .addr_out (addr_out),
    .M1_L     (M1_L),
    .MREQ_L   (MREQ_L),
    .IORQ_L   (IORQ_L),
    .RD_L     (RD_L),
    .WR_L     (WR_L),
    .RFSH_L   (RFSH_L),
    .HALT_L   (HALT_L),
    .BUSACK_L (BUSACK_L),
    .INT_L    (INT_L),
    .NMI_L    (NMI_L),
    .WAIT_L   (WAIT_L),
    .BUSREQ_L (BUSREQ_L)
  );

  task automatic cyc(input string tag, input logic [15:0] exp_addr, input logic [7:0] exp_strb);
    @(negedge clk);
    n_checks++;
    assert (addr_out === exp_addr) else begin
      n_fail++;
      $error("FAIL %s addr: observed %h expected %h", tag, addr_out, exp_addr);
    end
    n_checks++;
    assert (strb === exp_strb) else begin
      n_fail++;
      $error("FAIL %s strobes: observed %b expected %b", tag, strb, exp_strb);
    end
  endtask

  // Plain four-clock opcode fetch at pc with refresh address r
  task automatic fetch(input string tag, input logic [15:0] pc, input logic [7:0] r,
                       input logic [7:0] op);
    cyc({tag, "_T1"}, pc, S_M1);
    cyc({tag, "_T2"}, pc, S_M1);
    data_in = op;
    cyc({tag, "_T3"}, {8'h00, r}, S_R3);
    data_in = 8'h00;
    cyc({tag, "_T4"}, {8'h00, r}, S_R4);
  endtask

  initial begin
    rst      = 1'b1;
    data_in  = 8'h00;
    INT_L    = 1'b1;
    NMI_L    = 1'b1;
    WAIT_L   = 1'b1;
    BUSREQ_L = 1'b1;

    // Reset state
    cyc("rst_a", 16'h0000, S_IDLE);
    cyc("rst_b", 16'h0000, S_IDLE);
    rst = 1'b0;

    // NOP stream: M1 every 4 clocks, PC and R both counting
    for (int i = 0; i < 3; i++) begin
      fetch("nop", 16'(i), 8'(i), 8'h00);
    end

    // JP 1234 from address 0003
    fetch("jp", 16'h0003, 8'h03, 8'hC3);
    cyc("mrl_T1", 16'h0004, S_MR);
    cyc("mrl_T2", 16'h0004, S_MR);
    data_in = 8'h34;
    cyc("mrl_T3", 16'h0004, S_IDLE);
    data_in = 8'h00;
    cyc("mrh_T1", 16'h0005, S_MR);
    cyc("mrh_T2", 16'h0005, S_MR);
    data_in = 8'h12;
    cyc("mrh_T3", 16'h0005, S_IDLE);
    data_in = 8'h00;

    // Two wait states; opcode taken from the last TW only
    cyc("wt_T1", 16'h1234, S_M1);
    cyc("wt_T2", 16'h1234, S_M1);
    WAIT_L  = 1'b0;
    data_in = 8'hC3;
    cyc("wt_TW1", 16'h1234, S_M1);
    cyc("wt_TW2", 16'h1234, S_M1);
    WAIT_L  = 1'b1;
    data_in = 8'h00;
    cyc("wt_T3", 16'h0004, S_R3);
    cyc("wt_T4", 16'h0004, S_R4);

    // EI with INT pending: one more instruction, then acknowledge
    INT_L = 1'b0;
    fetch("ei", 16'h1235, 8'h05, 8'hFB);
    fetch("ei_next", 16'h1236, 8'h06, 8'h00);
    cyc("ia_T1", 16'h1237, S_IA);
    cyc("ia_T2", 16'h1237, S_IA);
    cyc("ia_TW1", 16'h1237, S_IA);
    cyc("ia_TW2", 16'h1237, S_IA);
    cyc("ia_T3", 16'h0007, S_R3);
    cyc("ia_T4", 16'h0007, S_R4);

    // EI then DI with INT still held: DI wins, INT ignored
    fetch("ei2", 16'h0038, 8'h08, 8'hFB);
    fetch("di", 16'h0039, 8'h09, 8'hF3);
    fetch("di_next", 16'h003A, 8'h0A, 8'h00);
    INT_L = 1'b1;

    // EI, HALT, halted fetches at fixed PC, then NMI
    fetch("ei3", 16'h003B, 8'h0B, 8'hFB);
    fetch("halt", 16'h003C, 8'h0C, 8'h76);
    cyc("h1_T1", 16'h003D, S_M1H);
    cyc("h1_T2", 16'h003D, S_M1H);
    data_in = 8'hC3;
    cyc("h1_T3", 16'h000D, S_R3H);
    data_in = 8'h00;
    cyc("h1_T4", 16'h000D, S_R4H);
    cyc("h2_T1", 16'h003D, S_M1H);
    cyc("h2_T2", 16'h003D, S_M1H);
    NMI_L = 1'b0;
    cyc("h2_T3", 16'h000E, S_R3H);
    cyc("h2_T4", 16'h000E, S_R4H);
    fetch("nmi_dummy", 16'h003D, 8'h0F, 8'hC3);
    NMI_L = 1'b1;

    // After NMI IFF1 is clear: a held INT must not be acknowledged
    INT_L = 1'b0;
    fetch("nmi_vec", 16'h0066, 8'h10, 8'h00);
    fetch("nmi_vec1", 16'h0067, 8'h11, 8'h00);
    INT_L = 1'b1;

    // Bus request mid-M1: granted only after T4
    cyc("br_T1", 16'h0068, S_M1);
    BUSREQ_L = 1'b0;
    cyc("br_T2", 16'h0068, S_M1);
    cyc("br_T3", 16'h0012, S_R3);
    cyc("br_T4", 16'h0012, S_R4);
    cyc("bg_1", 16'h0000, S_BG);
    cyc("bg_2", 16'h0000, S_BG);
    BUSREQ_L = 1'b1;
    cyc("bg_rel", 16'h0069, S_M1);

    // Reset in mid-cycle
    rst = 1'b1;
    cyc("rst_mid", 16'h0000, S_IDLE);
    rst = 1'b0;
    cyc("rst_T1", 16'h0000, S_M1);
    cyc("rst_T2", 16'h0000, S_M1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
